mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 142 ++++++++++++++
 tb/tb_mdu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU with HI/LO registers,
// single-cycle MTHI/MTLO, and a pipeline stall for dependent D-stage MD ops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_is_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  logic [31:0] r_a;
  logic [31:0] r_b;
  op_e         r_op;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_md_op;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;
  logic        w_wr_en;

  // Multi-cycle ops occupy codes 000..011, i.e. op[2] clear.
  assign w_md_op = start & ~op[2];

  assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_prod_u = {32'h0, r_a} * {32'h0, r_b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // with remainder 0 instead of overflowing a signed divider.
  assign w_a_mag = r_a[31] ? -r_a : r_a;
  assign w_b_mag = r_b[31] ? -r_b : r_b;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_q_s   = (r_a[31] ^ r_b[31]) ? -w_q_mag : w_q_mag;
  assign w_r_s   = r_a[31] ? -w_r_mag : w_r_mag;

  // Select the result for the latched op; a zero divisor suppresses the write.
  always_comb begin
    w_hi_res = '0;
    w_lo_res = '0;
    w_wr_en  = 1'b0;
    case (r_op)
      OP_MULT: begin
        {w_hi_res, w_lo_res} = w_prod_s;
        w_wr_en = 1'b1;
      end
      OP_MULTU: begin
        {w_hi_res, w_lo_res} = w_prod_u;
        w_wr_en = 1'b1;
      end
      OP_DIV: begin
        w_hi_res = w_r_s;
        w_lo_res = w_q_s;
        w_wr_en  = (r_b != '0);
      end
      OP_DIVU: begin
        w_hi_res = r_a % r_b;
        w_lo_res = r_a / r_b;
        w_wr_en  = (r_b != '0);
      end
      default: ;
    endcase
  end

  // Operand latch, busy counter and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= OP_MULT;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else if (!r_busy) begin
      if (start) begin
        case (op_e'(op))
          OP_MULT, OP_MULTU: begin
            r_a    <= A;
            r_b    <= B;
            r_op   <= op_e'(op);
            r_cnt  <= 4'(MULT_CYCLES);
            r_busy <= 1'b1;
          end
          OP_DIV, OP_DIVU: begin
            r_a    <= A;
            r_b    <= B;
            r_op   <= op_e'(op);
            r_cnt  <= 4'(DIV_CYCLES);
            r_busy <= 1'b1;
          end
          OP_MTHI: r_hi <= A;
          OP_MTLO: r_lo <= A;
          default: ;
        endcase
      end
    end else if (r_cnt == 4'd1) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      if (w_wr_en) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end else begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign busy  = r_busy;
  assign stall = D_is_md & (r_busy | w_md_op);
  assign HI    = r_hi;
  assign LO    = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu with hand-computed HI/LO results.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        D_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .A       (A),
    .B       (B),
    .D_is_md (D_is_md),
    .busy    (busy),
    .stall   (stall),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op and follow it to completion; optionally poke
  // extra starts while busy, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el, input logic md, input bit poke);
    D_is_md = md;
    start = 1'b1; op = o; A = a; B = b;
    #1;
    check_val({tag, "_stall_start"}, 32'(stall), 32'(md));
    check_val({tag, "_idle_before"}, 32'(busy), 32'd0);
    step;
    start = 1'b0; A = 32'hDEADBEEF; B = 32'h13579BDF;
    for (int c = 1; c <= n; c++) begin
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_stall_busy"}, 32'(stall), 32'(md));
      check_val({tag, "_hi_hold"}, HI, m_hi);
      check_val({tag, "_lo_hold"}, LO, m_lo);
      if (poke && c == 2) begin start = 1'b1; op = 3'b011; A = 32'd100; B = 32'd7; end
      if (poke && c == 3) begin start = 1'b1; op = 3'b100; A = 32'h77777777; end
      step;
      start = 1'b0;
    end
    m_hi = eh;
    m_lo = el;
    check_val({tag, "_busy_done"}, 32'(busy), 32'd0);
    check_val({tag, "_stall_done"}, 32'(stall), 32'd0);
    check_val({tag, "_hi"}, HI, m_hi);
    check_val({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; A = '0; B = '0; D_is_md = 1'b1;
    repeat (2) step;
    check_val("rst_hi", HI, 32'd0);
    check_val("rst_lo", LO, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    step;
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_stall", 32'(stall), 32'd0);

    run_op("mult",   3'b000, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b1);
    run_op("multu",  3'b001, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b1, 1'b0);
    run_op("mult_m1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h00000000, 32'h00000001, 1'b1, 1'b0);
    run_op("multu_m1", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
    run_op("div",    3'b010, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0);
    run_op("divu",   3'b011, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b1, 1'b1);
    run_op("div_ovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
    run_op("div_nd", 3'b010, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu_big", 3'b011, 32'hFFFFFFFF, 32'h10, 10, 32'hF, 32'h0FFFFFFF, 1'b1, 1'b0);

    D_is_md = 1'b1;
    start = 1'b1; op = 3'b100; A = 32'h1234;
    #1;
    check_val("mthi_stall", 32'(stall), 32'd0);
    step;
    start = 1'b0;
    m_hi = 32'h1234;
    check_val("mthi_hi", HI, m_hi);
    check_val("mthi_lo", LO, m_lo);
    check_val("mthi_busy", 32'(busy), 32'd0);

    run_op("div0", 3'b010, 32'd5, 32'd0, 10, m_hi, m_lo, 1'b1, 1'b0);

    start = 1'b1; op = 3'b101; A = 32'hCAFEF00D;
    step;
    start = 1'b0;
    m_lo = 32'hCAFEF00D;
    check_val("mtlo_lo", LO, m_lo);
    check_val("mtlo_hi", HI, m_hi);
    check_val("mtlo_busy", 32'(busy), 32'd0);

    start = 1'b1; op = 3'b110; A = 32'hFFFF0000; B = 32'd1;
    #1;
    check_val("nop6_stall", 32'(stall), 32'd0);
    step;
    op = 3'b111;
    step;
    start = 1'b0;
    check_val("nop_hi", HI, m_hi);
    check_val("nop_lo", LO, m_lo);
    check_val("nop_busy", 32'(busy), 32'd0);

    start = 1'b1; op = 3'b010; A = 32'd100; B = 32'd7;
    step;
    start = 1'b0;
    repeat (3) step;
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_hi", HI, 32'd0);
    check_val("abort_lo", LO, 32'd0);
    #2 reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int c = 0; c < 10; c++) begin
      step;
      check_val("abort_busy_after", 32'(busy), 32'd0);
      check_val("abort_hi_after", HI, m_hi);
      check_val("abort_lo_after", LO, m_lo);
    end

    reset = 1'b1; start = 1'b1; op = 3'b100; A = 32'h5555;
    step;
    check_val("rst_start_hi", HI, 32'd0);
    check_val("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    run_op("post_rst", 3'b001, 32'd3, 32'd5, 5, 32'd0, 32'd15, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
